pattern_generator: RTL and testbench
====================================

Name: pattern_generator

Overview:
- Playback counterpart of the capture-side logic analyzer.
- Software loads 72-bit samples into an internal RAM through a 32-bit word-select write port.
- On command, the block replays the samples in order on a 72-bit valid/ready stream, either once or looping.
- Used to drive datapath stimulus in the same register-controlled fashion the analyzer uses for capture.

Parameters:
- ADDR_WIDTH, 10: RAM depth is 2**ADDR_WIDTH entries.
- DATA_WIDTH, 72: sample width. Fixed at 72 by the 32/32/8 load split.

Ports:
- clk  in  1  single clock for all logic.
- reset_n  in  1  asynchronous active-low reset.
- load_addr  in  ADDR_WIDTH  RAM entry targeted by a load.
- word_select  in  2  00 = bits[31:0], 01 = bits[63:32], 10 = bits[71:64] plus commit, 11 = ignored.
- write_data  in  32  load data word.
- write_strobe  in  1  one-cycle load qualifier.
- pattern_length  in  ADDR_WIDTH+1  number of entries to play; valid range 1..2**ADDR_WIDTH.
- loop_enable  in  1  when 1, wrap to entry 0 after the last entry.
- start  in  1  one-cycle playback start pulse.
- stop  in  1  one-cycle abort pulse.
- pattern_ready  in  1  downstream accept.
- pattern_data  out  DATA_WIDTH  current sample.
- pattern_valid  out  1  pattern_data is valid.
- busy  out  1  state is PRIME or RUN.
- done  out  1  single-shot playback completed.
- samples_played  out  32  transfers since the last start.
- loop_count  out  16  completed wraps since the last start.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State goes to IDLE.
  - Staging register, pointer, pattern_valid, busy, done, samples_played and loop_count all clear to 0.
  - pattern_data reads 0.
  - RAM contents are not reset.
  - Reset asserted mid-playback drops pattern_valid immediately.
- Load path, accepted only when busy=0 (loads while busy are dropped silently):
  - word_select 00: stage[31:0] <= write_data.
  - word_select 01: stage[63:32] <= write_data.
  - word_select 10: RAM[load_addr] <= {write_data[7:0], stage[63:0]}. The stage is kept, so repeated low words need not be rewritten.
  - word_select 11: no effect.
- RAM: synchronous read, one-cycle latency. Read address rd_addr = ptr+1 (or 0 on wrap) when a transfer occurs, else ptr. RAM output is registered every cycle.
- FSM states IDLE, PRIME, RUN, DONE:
  - IDLE or DONE, start=1, pattern_length!=0 → PRIME. ptr=0, counters cleared, done cleared.
  - start with pattern_length=0 is ignored; state unchanged.
  - PRIME → RUN after one cycle. With start at edge N, pattern_valid=1 is first visible after edge N+2.
  - RUN: pattern_valid=1. Transfer = pattern_valid && pattern_ready. pattern_data stays stable while valid and not ready.
  - RUN, transfer on entry index pattern_length-1, loop_enable=1: ptr wraps to 0, loop_count increments (wrapping), streaming continues with no bubble.
  - RUN, transfer on the last entry, loop_enable=0 → DONE. pattern_valid=0, done=1 and held until the next start or reset.
  - In RUN, every transfer increments samples_played (32-bit wrap), giving full throughput of one sample per cycle.
- stop in any state → IDLE on the next edge: pattern_valid=0, done=0, counters held for readback. stop takes priority over a simultaneous start.
- start while busy is ignored.
- pattern_length and loop_enable are sampled at start and held internally; changes during playback have no effect.
- pattern_length=2**ADDR_WIDTH plays every RAM entry. Pointer wrap from 2**ADDR_WIDTH-1 to 0 is natural.

Test Plan:
- Load entry 5: writes 11111111 (sel 00), 22222222 (01), 000000AB (10 to addr 5). Then length=6, start → sixth sample = 72'hAB_22222222_11111111.
- Load entries 0..3 with values 0..3, length=4, loop=0, ready held 1, start at edge N → valid after N+2. Data 0,1,2,3 on consecutive cycles. done=1, samples_played=4, valid=0 after the last transfer.
- Same load, ready toggled 1,0,0,1,... → each sample is held stable while ready=0, order is preserved, no duplicate or skipped samples.
- length=3, loop=1, ready=1 for 10 cycles after the first valid → data 0,1,2,0,1,2,0,1,2,0. loop_count=3. Then stop → valid=0 next cycle, done=0, busy=0.
- Corner cases:
  - start with length=0 → state stays IDLE.
  - start and stop in the same cycle → IDLE.
  - Load attempted during RUN → the target entry is unchanged on a later playback.
  - reset_n pulsed low mid-RUN → all outputs 0 asynchronously, RAM contents still intact on the next playback.

Source files
------------

// File: rtl/pattern_generator.sv
// pattern_generator: software-loaded 72-bit sample RAM replayed in order on a
// valid/ready stream, single-shot or looping. Samples are loaded 32/32/8 bits
// at a time through a staging register. The last (8-bit) write commits the
// staged sample into the RAM.
module pattern_generator #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 72
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [1:0]            word_select,
  input  logic [31:0]           write_data,
  input  logic                  write_strobe,
  input  logic [ADDR_WIDTH:0]   pattern_length,
  input  logic                  loop_enable,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  pattern_ready,
  output logic [DATA_WIDTH-1:0] pattern_data,
  output logic                  pattern_valid,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           samples_played,
  output logic [15:0]           loop_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PRIME = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   LEN_ONE = 1;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic                  loop_q, loop_d;
  logic [31:0]           samples_q, samples_d;
  logic [15:0]           loops_q, loops_d;
  logic [63:0]           stage_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] ram_q;
  logic [ADDR_WIDTH-1:0] rd_addr;

  logic transfer;
  logic last_entry;
  logic load_en;

  // Status outputs decode directly from the state register, so an async
  // reset drops them without waiting for a clock.
  assign pattern_valid  = (state_q == RUN);
  assign busy           = (state_q == PRIME) || (state_q == RUN);
  assign done           = (state_q == DONE);
  assign pattern_data   = pattern_valid ? ram_q : '0;
  assign samples_played = samples_q;
  assign loop_count     = loops_q;

  assign transfer   = pattern_valid && pattern_ready;
  assign last_entry = ({1'b0, ptr_q} == (len_q - LEN_ONE));
  assign load_en    = write_strobe && !busy;

  // Next-state logic for the playback FSM, pointer and counters.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d   = state_q;
    ptr_d     = ptr_q;
    len_d     = len_q;
    loop_d    = loop_q;
    samples_d = samples_q;
    loops_d   = loops_q;

    if (stop) begin
      // Abort wins over everything, including a start in the same cycle.
      // Counters are held so software can read how far playback got.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start && (pattern_length != '0)) begin
            state_d   = PRIME;
            ptr_d     = '0;
            len_d     = pattern_length;
            loop_d    = loop_enable;
            samples_d = '0;
            loops_d   = '0;
          end
        end
        PRIME: begin
          // One cycle for the RAM read of entry 0 to land in ram_q.
          state_d = RUN;
        end
        RUN: begin
          if (transfer) begin
            samples_d = samples_q + 32'd1;
            if (last_entry) begin
              ptr_d = '0;
              if (loop_q) begin
                loops_d = loops_q + 16'd1;
              end else begin
                state_d = DONE;
              end
            end else begin
              ptr_d = ptr_q + PTR_ONE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Read one entry ahead on a transfer so the next sample is ready with no
  // bubble; otherwise re-read the current entry to hold the output stable.
  assign rd_addr = ptr_d;

  // Control and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      len_q     <= '0;
      loop_q    <= 1'b0;
      samples_q <= '0;
      loops_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      len_q     <= len_d;
      loop_q    <= loop_d;
      samples_q <= samples_d;
      loops_q   <= loops_d;
    end
  end

  // Staging register for the low 64 bits of a sample; kept after commit so
  // repeated low words need not be rewritten.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_q <= '0;
    end else if (load_en) begin
      case (word_select)
        2'b00:   stage_q[31:0]  <= write_data;
        2'b01:   stage_q[63:32] <= write_data;
        default: stage_q        <= stage_q;
      endcase
    end
  end

  // Sample RAM with a commit write port and a registered synchronous read.
  // NOTE: the RAM and its read register have no reset so they map onto block
  // RAM; pattern_data is gated by pattern_valid to read 0 in reset.
  always_ff @(posedge clk) begin
    if (load_en && (word_select == 2'b10)) begin
      mem[load_addr] <= {write_data[7:0], stage_q};
    end
    ram_q <= mem[rd_addr];
  end

endmodule

// File: tb/tb_pattern_generator.sv
// Directed testbench for pattern_generator. Inputs are driven 1 time unit
// after each rising edge and outputs are sampled there too, away from the
// edge that consumes them.
module tb_pattern_generator;

  localparam int AW = 10;
  localparam int DW = 72;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] load_addr;
  logic [1:0]    word_select;
  logic [31:0]   write_data;
  logic          write_strobe;
  logic [AW:0]   pattern_length;
  logic          loop_enable;
  logic          start;
  logic          stop;
  logic          pattern_ready;
  logic [DW-1:0] pattern_data;
  logic          pattern_valid;
  logic          busy;
  logic          done;
  logic [31:0]   samples_played;
  logic [15:0]   loop_count;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] exp_mem [6];

  pattern_generator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .load_addr      (load_addr),
    .word_select    (word_select),
    .write_data     (write_data),
    .write_strobe   (write_strobe),
    .pattern_length (pattern_length),
    .loop_enable    (loop_enable),
    .start          (start),
    .stop           (stop),
    .pattern_ready  (pattern_ready),
    .pattern_data   (pattern_data),
    .pattern_valid  (pattern_valid),
    .busy           (busy),
    .done           (done),
    .samples_played (samples_played),
    .loop_count     (loop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [AW-1:0] addr, input logic [1:0] sel, input logic [31:0] data);
    load_addr    = addr;
    word_select  = sel;
    write_data   = data;
    write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
  endtask

  task automatic load_entry(input logic [AW-1:0] addr, input logic [DW-1:0] value);
    write_word(addr, 2'b00, value[31:0]);
    write_word(addr, 2'b01, value[63:32]);
    write_word(addr, 2'b10, {24'h0, value[71:64]});
  endtask

  // Start asserted after edge N: valid must be low after N+1, high after N+2.
  task automatic start_play(input int len, input logic lp);
    pattern_length = (AW + 1)'(len);
    loop_enable    = lp;
    start          = 1'b1;
    tick();
    start          = 1'b0;
    check("prime_valid_low", DW'(pattern_valid), DW'(0));
    check("prime_busy", DW'(busy), DW'(1));
    tick();
    check("run_valid_high", DW'(pattern_valid), DW'(1));
  endtask

  // Single-shot playback with ready held high; expects one sample per cycle.
  task automatic play_once(input int len, input string tag);
    pattern_ready = 1'b1;
    start_play(len, 1'b0);
    for (int i = 0; i < len; i++) begin
      check($sformatf("%s_data%0d", tag, i), pattern_data, exp_mem[i]);
      tick();
    end
    check({tag, "_done"}, DW'(done), DW'(1));
    check({tag, "_valid_off"}, DW'(pattern_valid), DW'(0));
    check({tag, "_busy_off"}, DW'(busy), DW'(0));
    check({tag, "_samples"}, DW'(samples_played), DW'(len));
  endtask

  initial begin
    logic [1:0] rdy_pat;
    int         exp_idx;

    reset_n = 1'b0; load_addr = '0; word_select = 2'b00; write_data = '0;
    write_strobe = 1'b0; pattern_length = '0; loop_enable = 1'b0;
    start = 1'b0; stop = 1'b0; pattern_ready = 1'b0;

    exp_mem[0] = 72'h0;
    exp_mem[1] = 72'h1;
    exp_mem[2] = 72'h2;
    exp_mem[3] = 72'h3;
    exp_mem[4] = 72'h4;
    exp_mem[5] = 72'hAB_22222222_11111111;

    #12;
    check("rst_valid", DW'(pattern_valid), DW'(0));
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_done", DW'(done), DW'(0));
    check("rst_data", pattern_data, DW'(0));
    check("rst_samples", DW'(samples_played), DW'(0));
    check("rst_loops", DW'(loop_count), DW'(0));
    tick();
    reset_n = 1'b1;
    tick();

    // Entry 5 through explicit word writes, then entries 0..4.
    write_word(10'd5, 2'b00, 32'h11111111);
    write_word(10'd5, 2'b01, 32'h22222222);
    write_word(10'd5, 2'b10, 32'h000000AB);
    for (int i = 0; i < 5; i++) load_entry(AW'(i), exp_mem[i]);
    // Ignored select code: must not commit anything.
    write_word(10'd0, 2'b11, 32'hDEADBEEF);

    play_once(6, "len6");
    play_once(4, "len4");

    // Backpressure: ready pattern 1,0,0,1 repeating; each sample must hold
    // while not accepted and appear exactly once in order.
    rdy_pat = 2'b00;
    pattern_ready = 1'b1;
    start_play(4, 1'b0);
    exp_idx = 0;
    for (int cyc = 0; cyc < 40 && exp_idx < 4; cyc++) begin
      pattern_ready = (rdy_pat == 2'd0) || (rdy_pat == 2'd3);
      rdy_pat++;
      if (pattern_valid) begin
        check($sformatf("bp_cyc%0d", cyc), pattern_data, exp_mem[exp_idx]);
        if (pattern_ready) exp_idx++;
      end else begin
        check($sformatf("bp_early_drop%0d", cyc), DW'(pattern_valid), DW'(1));
      end
      tick();
    end
    check("bp_all_sent", DW'(exp_idx), DW'(4));
    check("bp_done", DW'(done), DW'(1));
    check("bp_samples", DW'(samples_played), DW'(4));

    // Looping playback: 10 transfers over 3 entries wrap three times.
    pattern_ready = 1'b1;
    start_play(3, 1'b1);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("loop_data%0d", i), pattern_data, exp_mem[i % 3]);
      tick();
    end
    pattern_ready = 1'b0;
    check("loop_count", DW'(loop_count), DW'(3));
    check("loop_samples", DW'(samples_played), DW'(10));
    check("loop_still_valid", DW'(pattern_valid), DW'(1));
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_valid", DW'(pattern_valid), DW'(0));
    check("stop_done", DW'(done), DW'(0));
    check("stop_busy", DW'(busy), DW'(0));
    check("stop_samples_held", DW'(samples_played), DW'(10));

    // start with length 0 is ignored.
    pattern_length = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("len0_busy", DW'(busy), DW'(0));
    tick();
    check("len0_valid", DW'(pattern_valid), DW'(0));

    // start and stop together: stop wins.
    pattern_length = 11'd4;
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("startstop_busy", DW'(busy), DW'(0));
    tick();
    check("startstop_valid", DW'(pattern_valid), DW'(0));

    // A load attempted while busy must be dropped.
    pattern_ready = 1'b0;
    start_play(4, 1'b1);
    load_entry(10'd2, 72'hFF_EEEEEEEE_DDDDDDDD);
    check("busy_load_hold", pattern_data, exp_mem[0]);

    // Asynchronous reset mid-run.
    pattern_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("arst_valid", DW'(pattern_valid), DW'(0));
    check("arst_busy", DW'(busy), DW'(0));
    check("arst_data", pattern_data, DW'(0));
    check("arst_samples", DW'(samples_played), DW'(0));
    check("arst_loops", DW'(loop_count), DW'(0));
    tick();
    reset_n = 1'b1;
    tick();

    // RAM survives reset and the busy-time load never landed.
    play_once(6, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
